train_scheduler: RTL and testbench
==================================

TRAIN_SCHEDULER -- requirements
Module: train_scheduler

Interface
REQ-001 SHALL have parameter N_ROWS, default 784, meaning input-vector length (rows of invec/weight).
REQ-002 SHALL have parameter N_COLS, default 40, meaning samples per batch (columns of invec/z/ycap).
REQ-003 SHALL have parameter EPOCH_W, default 4, meaning width of epoch count.
REQ-004 SHALL have port clk, input, 1, the single clock; rising edge active.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port start, input, 1, which begins a training run when sampled high in IDLE.
REQ-007 SHALL have port abort, input, 1, which forces a synchronous return to IDLE.
REQ-008 SHALL have port stall, input, 1, datapath back-pressure that freezes counters and state.
REQ-009 SHALL have port epoch_max, input, EPOCH_W, the number of epochs, sampled at start.
REQ-010 SHALL have port phase, output, 3, the current state encoding: IDLE=0, LOAD=1, FWD=2, SIG=3, BP=4, DONE=5.
REQ-011 SHALL have port row_idx, output, clog2(N_ROWS), the current row index.
REQ-012 SHALL have port col_idx, output, clog2(N_COLS), the current column index.
REQ-013 SHALL have port first, output, 1, high on the first beat of an accumulation (FWD row_idx==0; BP col_idx==0).
REQ-014 SHALL have port last, output, 1, high on the final beat of the current phase.
REQ-015 SHALL have port epoch, output, EPOCH_W, the current epoch, 1-based.
REQ-016 SHALL have port busy, output, 1, high in LOAD, FWD, SIG and BP.
REQ-017 SHALL have port done, output, 1, a one-cycle pulse on entry to DONE.
REQ-018 SHALL have port cycles, output, 32, the active-cycle count (see Configuration).

Function
REQ-019 SHALL advance state and indices only on beats where busy=1 and stall=0; a stall beat holds every output.
REQ-020 SHALL go from IDLE to LOAD on the cycle after start=1, with row_idx=0, col_idx=0 and epoch=1, latching epoch_max; an epoch_max of 0 SHALL be treated as 1.
REQ-021 SHALL in LOAD and FWD step row-fast: row wraps N_ROWS-1 to 0 and increments col; last is high at (N_ROWS-1, N_COLS-1).
REQ-022 SHALL go from LOAD to FWD after its last beat, and from FWD to SIG after its last beat, with indices reset to 0.
REQ-023 SHALL in SIG step col_idx 0..N_COLS-1 with row_idx=0, then enter BP with indices 0.
REQ-024 SHALL in BP step col-fast: col wraps N_COLS-1 to 0 and increments row; last is high at (N_ROWS-1, N_COLS-1).
REQ-025 SHALL after the BP last beat enter DONE if epoch equals the latched max; otherwise it SHALL increment epoch and enter FWD, skipping LOAD.
REQ-026 SHALL return from DONE to IDLE on the next cycle; start is ignored outside IDLE.
REQ-027 SHALL on abort=1 in any state enter IDLE next cycle with indices 0, regardless of stall; abort takes priority over start.
REQ-028 SHALL give phase lengths, with no stalls, of LOAD, FWD and BP = N_ROWS*N_COLS beats each and SIG = N_COLS beats.
REQ-029 SHALL drive first, last and done as 0 whenever busy=0.

Reset
REQ-030 SHALL on rst asynchronously set phase=IDLE, row_idx=0, col_idx=0, epoch=0, first=0, last=0, busy=0, done=0 and cycles=0.
REQ-031 SHALL treat rst mid-run like abort, except that it is immediate; no partial epoch is resumed.

Configuration
REQ-032 SHALL with macro TRAIN_PERF_CNT_EN defined count cycles where busy=1 and stall=0, clearing on start and saturating at 2^32-1.
REQ-033 SHALL without TRAIN_PERF_CNT_EN tie cycles to 0 and infer no counter logic.

Structure
REQ-034 SHALL take its phase encoding type and the default N_ROWS/N_COLS constants from shared package nn_pkg.
REQ-035 SHALL implement the 2-D index stepping as one sub-module, idx_counter2d, with inputs clear, en and row_fast, and outputs row, col, wrap and last.

Verification
REQ-036 SHALL verify that N_ROWS=4, N_COLS=3, epoch_max=1, start pulse -> LOAD 12, FWD 12, SIG 3 and BP 12 beats, then one done pulse and IDLE, with cycles=39.
REQ-037 SHALL verify that epoch_max=3 -> exactly one LOAD, three FWD/SIG/BP passes with epoch=1,2,3, and done only after epoch 3.
REQ-038 SHALL verify that stall held 5 cycles at FWD (row 2, col 1) -> outputs frozen 5 cycles, no beat skipped, and cycles excludes the stall.
REQ-039 SHALL verify that abort at BP (row 1, col 2) -> phase=IDLE next cycle, no done pulse, and a subsequent start restarts at LOAD epoch 1.
REQ-040 SHALL verify that epoch_max=0 -> behaves as 1 epoch; that start during FWD is ignored; and that asynchronous rst mid-SIG clears all outputs without waiting for clk.

Source files
------------

// File: rtl/nn_pkg.sv
// nn_pkg -- shared definitions for the training-sequencer slice.
//
// Contents:
//   phase_t     : training phase encoding (IDLE=0 LOAD=1 FWD=2 SIG=3 BP=4 DONE=5)
//   DEF_N_ROWS  : default input-vector length (rows of invec/weight)
//   DEF_N_COLS  : default samples per batch (columns of invec/z/ycap)
//   idx_width() : index width for a dimension, never narrower than one bit
package nn_pkg;

  typedef enum logic [2:0] {
    PH_IDLE = 3'd0,
    PH_LOAD = 3'd1,
    PH_FWD  = 3'd2,
    PH_SIG  = 3'd3,
    PH_BP   = 3'd4,
    PH_DONE = 3'd5
  } phase_t;

  localparam int unsigned DEF_N_ROWS = 784;
  localparam int unsigned DEF_N_COLS = 40;

  // A dimension of size 1 still needs a one-bit index so ports keep a legal range.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/idx_counter2d.sv
// idx_counter2d -- two-dimensional (row, col) index stepper.
//
// Ports:
//   clk      : clock, rising edge active
//   rst      : asynchronous active-high reset, indices to 0
//   clear    : synchronous return of both indices to 0 (beats en)
//   en       : advance one step this cycle
//   row_fast : 1 = row is the inner index, 0 = col is the inner index
//   row, col : current indices
//   wrap     : the inner index sits at its maximum (next step wraps it)
//   last     : both indices sit at their maximum
module idx_counter2d import nn_pkg::*; #(
  parameter int unsigned N_ROWS = DEF_N_ROWS,
  parameter int unsigned N_COLS = DEF_N_COLS,
  localparam int unsigned ROW_W = idx_width(N_ROWS),
  localparam int unsigned COL_W = idx_width(N_COLS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic             row_fast,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic             wrap,
  output logic             last
);

  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(N_ROWS - 1);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(N_COLS - 1);

  logic row_at_max;
  logic col_at_max;

  assign row_at_max = (row == ROW_MAX);
  assign col_at_max = (col == COL_MAX);
  assign wrap       = row_fast ? row_at_max : col_at_max;
  assign last       = row_at_max && col_at_max;

  // The inner index counts every step; the outer index moves only when the
  // inner one wraps. Past the final position both indices fold back to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row <= '0;
      col <= '0;
    end else if (clear) begin
      row <= '0;
      col <= '0;
    end else if (en) begin
      if (row_fast) begin
        if (row_at_max) begin
          row <= '0;
          col <= col_at_max ? '0 : col + 1'b1;
        end else begin
          row <= row + 1'b1;
        end
      end else begin
        if (col_at_max) begin
          col <= '0;
          row <= row_at_max ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/train_scheduler.sv
// train_scheduler -- sequences a training run through LOAD, then per epoch
// FWD, SIG and BP, then DONE, generating the row/col indices the datapath
// consumes.
//
// Parameters:
//   N_ROWS  : input-vector length (rows of invec/weight)
//   N_COLS  : samples per batch (columns of invec/z/ycap)
//   EPOCH_W : width of the epoch count
//
// Ports:
//   clk, rst  : clock (rising edge) and asynchronous active-high reset
//   start     : begin a run when sampled high in IDLE
//   abort     : synchronous return to IDLE, overrides start and stall
//   stall     : datapath back-pressure, freezes state and indices
//   epoch_max : number of epochs, latched at start (0 runs one epoch)
//   phase     : current phase (IDLE=0 LOAD=1 FWD=2 SIG=3 BP=4 DONE=5)
//   row_idx   : current row index
//   col_idx   : current column index
//   first     : first beat of an accumulation (FWD row 0, BP col 0)
//   last      : final beat of the current phase
//   epoch     : current epoch, 1-based
//   busy      : high in LOAD, FWD, SIG and BP
//   done      : one-cycle pulse on the beat that enters DONE
//   cycles    : active (busy and not stalled) cycle count
//
// Build option:
//   TRAIN_PERF_CNT_EN : when defined, cycles is a saturating 32-bit counter
//                       cleared on start; otherwise cycles is tied to 0.
module train_scheduler import nn_pkg::*; #(
  parameter int unsigned N_ROWS  = DEF_N_ROWS,
  parameter int unsigned N_COLS  = DEF_N_COLS,
  parameter int unsigned EPOCH_W = 4,
  localparam int unsigned ROW_W  = idx_width(N_ROWS),
  localparam int unsigned COL_W  = idx_width(N_COLS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               stall,
  input  logic [EPOCH_W-1:0] epoch_max,
  output logic [2:0]         phase,
  output logic [ROW_W-1:0]   row_idx,
  output logic [COL_W-1:0]   col_idx,
  output logic               first,
  output logic               last,
  output logic [EPOCH_W-1:0] epoch,
  output logic               busy,
  output logic               done,
  output logic [31:0]        cycles
);

  phase_t             state;
  logic [EPOCH_W-1:0] epoch_lat;

  logic beat;
  logic row_fast;
  logic cnt_clear;
  logic cnt_wrap;
  logic cnt_last;
  logic phase_last;
  logic run_start;

  // Phase decode is taken straight from the state register, so every
  // output below holds still on a stalled beat.
  assign busy = (state == PH_LOAD) || (state == PH_FWD) ||
                (state == PH_SIG)  || (state == PH_BP);

  // A beat is a cycle where the scheduler actually advances. An abort cycle
  // is not a beat: it neither steps indices nor counts as activity.
  assign beat = busy && !stall && !abort;

  assign run_start = (state == PH_IDLE) && start && !abort;

  // LOAD and FWD walk down a column before moving across; BP walks across a
  // row first. SIG uses the col-fast walk with row pinned at 0, so the
  // counter's wrap flag marks its final column.
  assign row_fast   = (state == PH_LOAD) || (state == PH_FWD);
  assign phase_last = (state == PH_SIG) ? cnt_wrap : cnt_last;

  // Indices return to 0 at every phase boundary and on abort.
  assign cnt_clear = abort || (beat && phase_last);

  idx_counter2d #(
    .N_ROWS(N_ROWS),
    .N_COLS(N_COLS)
  ) u_idx (
    .clk      (clk),
    .rst      (rst),
    .clear    (cnt_clear),
    .en       (beat),
    .row_fast (row_fast),
    .row      (row_idx),
    .col      (col_idx),
    .wrap     (cnt_wrap),
    .last     (cnt_last)
  );

  assign phase = state;
  assign last  = busy && phase_last;
  assign first = ((state == PH_FWD) && (row_idx == '0)) ||
                 ((state == PH_BP)  && (col_idx == '0));

  // done fires on the final BP beat of the final epoch, i.e. the beat whose
  // edge moves the FSM into DONE. Keeping it on that beat means done is only
  // ever seen while busy, and a stall or abort on that beat suppresses it.
  assign done = beat && (state == PH_BP) && cnt_last && (epoch == epoch_lat);

  // Phase sequencing. Abort wins over everything; otherwise a phase only
  // moves on its final unstalled beat. Later epochs re-enter FWD directly
  // because the input data stays loaded. Entering IDLE via abort drops the
  // epoch back to 0; finishing normally leaves the final epoch visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= PH_IDLE;
      epoch     <= '0;
      epoch_lat <= '0;
    end else if (abort) begin
      state <= PH_IDLE;
      epoch <= '0;
    end else begin
      unique case (state)
        PH_IDLE: begin
          if (start) begin
            state     <= PH_LOAD;
            epoch     <= EPOCH_W'(1);
            epoch_lat <= (epoch_max == '0) ? EPOCH_W'(1) : epoch_max;
          end
        end
        PH_LOAD: begin
          if (beat && phase_last) state <= PH_FWD;
        end
        PH_FWD: begin
          if (beat && phase_last) state <= PH_SIG;
        end
        PH_SIG: begin
          if (beat && phase_last) state <= PH_BP;
        end
        PH_BP: begin
          if (beat && phase_last) begin
            if (epoch == epoch_lat) begin
              state <= PH_DONE;
            end else begin
              state <= PH_FWD;
              epoch <= epoch + 1'b1;
            end
          end
        end
        PH_DONE: begin
          state <= PH_IDLE;
        end
        default: begin
          state <= PH_IDLE;
        end
      endcase
    end
  end

`ifdef TRAIN_PERF_CNT_EN
  logic [31:0] cycle_cnt;

  // Active-cycle counter: restarts with each run and sticks at all-ones
  // rather than wrapping, so a long run never reads as a short one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt <= '0;
    end else if (run_start) begin
      cycle_cnt <= '0;
    end else if (beat && (cycle_cnt != '1)) begin
      cycle_cnt <= cycle_cnt + 1'b1;
    end
  end

  assign cycles = cycle_cnt;
`else
  logic unused_run_start;

  assign unused_run_start = run_start;
  assign cycles           = '0;
`endif

endmodule

// File: tb/tb_train_scheduler.sv
// tb_train_scheduler -- randomized self-checking bench for train_scheduler
// with a 4-row, 3-column geometry. The expected beat sequence of a run is
// generated from the phase rules as a queue of (phase, row, col, epoch)
// records; each unstalled DUT cycle must match the head record and consume
// it, each stalled cycle must repeat it.
module tb_train_scheduler;

  localparam int NR = 4;
  localparam int NC = 3;
  localparam int EW = 4;

  localparam int ACT_NONE  = 0;
  localparam int ACT_STALL = 1;
  localparam int ACT_ABORT = 2;
  localparam int ACT_RESET = 3;

  logic          clk;
  logic          rst;
  logic          start;
  logic          abort;
  logic          stall;
  logic [EW-1:0] epoch_max;
  logic [2:0]    phase;
  logic [1:0]    row_idx;
  logic [1:0]    col_idx;
  logic          first;
  logic          last;
  logic [EW-1:0] epoch;
  logic          busy;
  logic          done;
  logic [31:0]   cycles;

  int vec_count;
  int miscompares;

  typedef struct {
    int ph;
    int row;
    int col;
    int ep;
    bit lst;
    bit fin;
  } beat_t;

  beat_t exp_q[$];

  train_scheduler #(
    .N_ROWS (NR),
    .N_COLS (NC),
    .EPOCH_W(EW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .stall    (stall),
    .epoch_max(epoch_max),
    .phase    (phase),
    .row_idx  (row_idx),
    .col_idx  (col_idx),
    .first    (first),
    .last     (last),
    .epoch    (epoch),
    .busy     (busy),
    .done     (done),
    .cycles   (cycles)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vec_count++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0d expected %0d at %0t",
               tag, observed, expected, $time);
    end
  endtask

  // Every output back at its reset/abort value.
  task automatic checkCleared(input string tag);
    checkOutput({tag, "_phase"}, 32'(phase), 0);
    checkOutput({tag, "_row"},   32'(row_idx), 0);
    checkOutput({tag, "_col"},   32'(col_idx), 0);
    checkOutput({tag, "_epoch"}, 32'(epoch), 0);
    checkOutput({tag, "_first"}, 32'(first), 0);
    checkOutput({tag, "_last"},  32'(last), 0);
    checkOutput({tag, "_busy"},  32'(busy), 0);
    checkOutput({tag, "_done"},  32'(done), 0);
  endtask

  // Expected beat sequence of a complete run, straight from the phase rules.
  function automatic void buildRun(input int emax);
    int e_eff;
    e_eff = (emax == 0) ? 1 : emax;
    exp_q.delete();
    for (int c = 0; c < NC; c++)
      for (int r = 0; r < NR; r++)
        exp_q.push_back('{1, r, c, 1, (r == NR-1 && c == NC-1), 1'b0});
    for (int ep = 1; ep <= e_eff; ep++) begin
      for (int c = 0; c < NC; c++)
        for (int r = 0; r < NR; r++)
          exp_q.push_back('{2, r, c, ep, (r == NR-1 && c == NC-1), 1'b0});
      for (int c = 0; c < NC; c++)
        exp_q.push_back('{3, 0, c, ep, (c == NC-1), 1'b0});
      for (int r = 0; r < NR; r++)
        for (int c = 0; c < NC; c++)
          exp_q.push_back('{4, r, c, ep, (r == NR-1 && c == NC-1),
                            (r == NR-1 && c == NC-1 && ep == e_eff)});
    end
  endfunction

  // One training run. Entered and left at 1 ns after a rising edge.
  // action fires once, at the first beat matching (tph, trow, tcol).
  task automatic applyStimulus(input int emax, input int stall_pct,
                               input int action, input int tph,
                               input int trow, input int tcol);
    int    e_eff;
    int    budget;
    int    stall_left;
    int    model_cycles;
    int    exp_cycles;
    bit    fired;
    bit    hit;
    bit    early;
    bit    exp_first;
    beat_t b;

    e_eff        = (emax == 0) ? 1 : emax;
    model_cycles = 0;
    stall_left   = 0;
    fired        = 1'b0;
    early        = 1'b0;
    budget       = 2000;

    epoch_max = EW'(emax);
    start     = 1'b1;
    abort     = 1'b0;
    stall     = 1'($urandom_range(0, 1));
    #1;
    checkOutput("idle_phase", 32'(phase), 0);
    checkOutput("idle_busy",  32'(busy), 0);
    checkOutput("idle_done",  32'(done), 0);
    @(posedge clk);
    #1;

    buildRun(emax);
    while (exp_q.size() > 0 && budget > 0) begin
      b   = exp_q[0];
      hit = !fired && (action != ACT_NONE) &&
            (b.ph == tph) && (b.row == trow) && (b.col == tcol);
      if (hit) fired = 1'b1;
      if (hit && action == ACT_STALL) stall_left = 5;
      if (stall_left > 0) begin
        stall = 1'b1;
        stall_left--;
      end else begin
        stall = ($urandom_range(0, 99) < stall_pct);
      end
      abort = hit && (action == ACT_ABORT);
      // start is noise while busy; on the abort beat it must lose to abort.
      start = abort ? 1'b1 : 1'($urandom_range(0, 1));
      #1;

      exp_first = (b.ph == 2 && b.row == 0) || (b.ph == 4 && b.col == 0);
      checkOutput("phase", 32'(phase),   b.ph);
      checkOutput("row",   32'(row_idx), b.row);
      checkOutput("col",   32'(col_idx), b.col);
      checkOutput("epoch", 32'(epoch),   b.ep);
      checkOutput("busy",  32'(busy),    1);
      checkOutput("first", 32'(first),   32'(exp_first));
      checkOutput("last",  32'(last),    32'(b.lst));
      checkOutput("done",  32'(done),    32'(b.fin && !stall && !abort));

      if (hit && action == ACT_RESET) begin
        // Assert reset between clock edges; outputs must clear at once.
        #2;
        rst = 1'b1;
        #1;
        checkCleared("async_rst");
        checkOutput("async_rst_cycles", cycles, 0);
        #2;
        rst   = 1'b0;
        start = 1'b0;
        stall = 1'b0;
        early = 1'b1;
        exp_q.delete();
      end else if (abort) begin
        @(posedge clk);
        #1;
        abort = 1'b0;
        start = 1'b0;
        stall = 1'b0;
        #1;
        checkCleared("abort");
        early = 1'b1;
        exp_q.delete();
      end else begin
        if (!stall) begin
          void'(exp_q.pop_front());
          model_cycles++;
        end
        @(posedge clk);
        #1;
      end
      budget--;
    end

    checkOutput("beat_budget", exp_q.size(), 0);
    abort = 1'b0;

    if (!early) begin
`ifdef TRAIN_PERF_CNT_EN
      exp_cycles = model_cycles;
`else
      exp_cycles = 0;
`endif
      // DONE: start here must be ignored.
      start = 1'b1;
      stall = 1'($urandom_range(0, 1));
      #1;
      checkOutput("done_phase",  32'(phase), 5);
      checkOutput("done_busy",   32'(busy),  0);
      checkOutput("done_pulse",  32'(done),  0);
      checkOutput("done_last",   32'(last),  0);
      checkOutput("done_epoch",  32'(epoch), e_eff);
      checkOutput("done_cycles", cycles,     exp_cycles);
      @(posedge clk);
      #1;
      start = 1'b0;
      #1;
      checkOutput("after_phase", 32'(phase), 0);
      checkOutput("after_epoch", 32'(epoch), e_eff);
      checkOutput("after_done",  32'(done),  0);
    end
  endtask

  initial begin
    vec_count   = 0;
    miscompares = 0;
    rst         = 1'b1;
    start       = 1'b0;
    abort       = 1'b0;
    stall       = 1'b0;
    epoch_max   = '0;

    #3;
    checkCleared("reset");
    checkOutput("reset_cycles", cycles, 0);
    #9;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single epoch, no back-pressure: 12 + 12 + 3 + 12 beats.
    applyStimulus(1, 0, ACT_NONE, 0, 0, 0);
    // Three epochs: one LOAD, then three FWD/SIG/BP passes.
    applyStimulus(3, 0, ACT_NONE, 0, 0, 0);
    // Five-cycle stall at FWD (row 2, col 1).
    applyStimulus(2, 0, ACT_STALL, 2, 2, 1);
    // Abort at BP (row 1, col 2), then a fresh run from LOAD epoch 1.
    applyStimulus(1, 20, ACT_ABORT, 4, 1, 2);
    applyStimulus(1, 0, ACT_NONE, 0, 0, 0);
    // epoch_max of 0 behaves as one epoch.
    applyStimulus(0, 15, ACT_NONE, 0, 0, 0);
    // Asynchronous reset mid-SIG, then a clean run.
    applyStimulus(2, 10, ACT_RESET, 3, 0, 1);
    applyStimulus(1, 0, ACT_NONE, 0, 0, 0);
    // Randomized runs with back-pressure.
    for (int i = 0; i < 4; i++)
      applyStimulus(int'($urandom_range(0, 3)), 25, ACT_NONE, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
